// File: rtl/pipe_stage_reg.sv
// Reusable pipeline boundary latch: DEPTH valid-tagged payload stages with
// hit-gated advance, whole-pipe flush, sticky halt capture and a stall counter.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      HALT_BIT  = 0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WIDTH-1:0] HALT_VAL = RESET_VAL | (WIDTH'(1) << HALT_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (RESET_VAL[HALT_BIT]) begin : g_bad_reset_val
        $error("pipe_stage_reg: RESET_VAL must not have HALT_BIT set");
    end

    typedef enum logic [2:0] {
        ACT_FROZEN,
        ACT_HALT,
        ACT_FLUSH,
        ACT_SHIFT,
        ACT_HOLD
    } act_t;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;
    logic             halt_seen;
    act_t             act;

    assign halt_seen  = vld[DEPTH-1] & stage[DEPTH-1][HALT_BIT];
    assign dout       = stage[DEPTH-1];
    assign dout_valid = vld[DEPTH-1];

    // One action per edge, resolved in strict priority order.
    always_comb begin
        act = ACT_HOLD;
        if (halted)
            act = ACT_FROZEN;
        else if (halt_seen)
            act = ACT_HALT;
        else if (en && flush)
            act = ACT_FLUSH;
        else if (en)
            act = ACT_SHIFT;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                stage[i] <= RESET_VAL;
            vld       <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            unique case (act)
                ACT_FROZEN: begin
                end
                ACT_HALT: begin
                    for (int unsigned i = 0; i < DEPTH; i++)
                        stage[i] <= HALT_VAL;
                    vld    <= '0;
                    halted <= 1'b1;
                end
                ACT_FLUSH: begin
                    for (int unsigned i = 0; i < DEPTH; i++)
                        stage[i] <= RESET_VAL;
                    vld <= '0;
                end
                ACT_SHIFT: begin
                    stage[0] <= din_valid ? din : RESET_VAL;
                    vld[0]   <= din_valid;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                        vld[i]   <= vld[i-1];
                    end
                end
                ACT_HOLD: begin
                    if (stall_cnt != CNT_MAX)
                        stall_cnt <= stall_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 3-deep/3-bit-counter instance and a 1-deep instance
// driven in parallel and compared against a queue-based reference model.
module tb_pipe_stage_reg;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en, flush, din_valid;
    logic [7:0] din;

    logic [7:0]  d0_dout, d1_dout;
    logic        d0_vld, d1_vld, d0_halted, d1_halted;
    logic [2:0]  d0_cnt;
    logic [15:0] d1_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(
        .WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .HALT_BIT(7), .CNT_W(3)
    ) u_deep (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .din(din), .din_valid(din_valid),
        .dout(d0_dout), .dout_valid(d0_vld), .halted(d0_halted), .stall_cnt(d0_cnt)
    );

    pipe_stage_reg #(
        .WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .HALT_BIT(7), .CNT_W(16)
    ) u_single (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .din(din), .din_valid(din_valid),
        .dout(d1_dout), .dout_valid(d1_vld), .halted(d1_halted), .stall_cnt(d1_cnt)
    );

    // Reference model: each pipe is a queue, newest entry at the front.
    typedef struct packed { logic v; logic [7:0] d; } ent_t;
    ent_t        mp [2][$];
    bit          mhalt [2];
    int unsigned mcnt  [2];
    int unsigned dep   [2] = '{3, 1};
    int unsigned cmax  [2] = '{7, 65535};

    function automatic void fill(input int k, input ent_t e);
        mp[k].delete();
        repeat (dep[k]) mp[k].push_back(e);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            fill(k, '{v: 1'b0, d: 8'h00});
            mhalt[k] = 1'b0;
            mcnt[k]  = 0;
        end
    endfunction

    function automatic void model_edge();
        ent_t tail;
        if (RST) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            tail = mp[k][$];
            if (mhalt[k]) begin
            end else if (tail.v && tail.d[7]) begin
                mhalt[k] = 1'b1;
                fill(k, '{v: 1'b0, d: 8'h80});
            end else if (en && flush) begin
                fill(k, '{v: 1'b0, d: 8'h00});
            end else if (en) begin
                mp[k].push_front(din_valid ? '{v: 1'b1, d: din} : '{v: 1'b0, d: 8'h00});
                void'(mp[k].pop_back());
            end else begin
                mcnt[k] = (mcnt[k] + 1 > cmax[k]) ? cmax[k] : mcnt[k] + 1;
            end
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        ent_t t0, t1;
        t0 = mp[0][$];
        t1 = mp[1][$];
        check_val("deep.dout",     32'(d0_dout),   32'(t0.d));
        check_val("deep.vld",      32'(d0_vld),    32'(t0.v));
        check_val("deep.halted",   32'(d0_halted), 32'(mhalt[0]));
        check_val("deep.cnt",      32'(d0_cnt),    mcnt[0]);
        check_val("single.dout",   32'(d1_dout),   32'(t1.d));
        check_val("single.vld",    32'(d1_vld),    32'(t1.v));
        check_val("single.halted", 32'(d1_halted), 32'(mhalt[1]));
        check_val("single.cnt",    32'(d1_cnt),    mcnt[1]);
    endtask

    task automatic cycle(input logic e, input logic f, input logic [7:0] d, input logic dv);
        en = e; flush = f; din = d; din_valid = dv;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0;
        model_reset();
        @(negedge CLK);
        check_all();
        check_val("reset.cnt", 32'(d1_cnt), 32'd0);
        RST = 1'b0;

        // single-stage latch: one edge of latency
        cycle(1'b1, 1'b0, 8'h5A, 1'b1);
        check_val("single.latency", 32'(d1_dout), 32'h5A);

        // 3-deep: push, hold, drain
        do_reset();
        cycle(1'b1, 1'b0, 8'h11, 1'b1);
        cycle(1'b1, 1'b0, 8'h22, 1'b1);
        cycle(1'b1, 1'b0, 8'h33, 1'b1);
        check_val("deep.first_out", 32'(d0_dout), 32'h11);
        repeat (4) cycle(1'b0, 1'b0, 8'hEE, 1'b1);
        check_val("deep.frozen", 32'(d0_dout), 32'h11);
        check_val("deep.stall4", 32'(d0_cnt), 32'd4);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_val("deep.second", 32'(d0_dout), 32'h22);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_val("deep.third", 32'(d0_dout), 32'h33);

        // flush ignored while stalled, honoured with en
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h41 + i), 1'b1);
        repeat (2) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check_val("flush.ignored", 32'(d0_vld), 32'd1);
        cycle(1'b1, 1'b1, 8'h7F, 1'b1);
        check_val("flush.bubble", 32'(d0_vld), 32'd0);

        // halt word with flush on the same edge is dropped
        cycle(1'b1, 1'b1, 8'h80, 1'b1);
        check_val("flush.drops_halt", 32'(d1_halted), 32'd0);

        // stall counter saturation
        do_reset();
        repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check_val("deep.sat", 32'(d0_cnt), 32'd7);
        check_val("single.cnt10", 32'(d1_cnt), 32'd10);

        // halt capture and sticky halted state
        do_reset();
        cycle(1'b1, 1'b0, 8'h80, 1'b1);
        check_val("single.halt_word", 32'(d1_dout), 32'h80);
        repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_val("single.halted", 32'(d1_halted), 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'(i % 2), 1'(i / 3), 8'(i), 1'b1);
        check_val("deep.halted", 32'(d0_halted), 32'd1);
        check_val("deep.halt_pat", 32'(d0_dout), 32'h80);
        do_reset();
        check_val("halt.cleared", 32'(d0_halted), 32'd0);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h21 + i), 1'b1);
        en = 1'b0;
        @(posedge CLK);
        model_edge();
        #2 RST = 1'b1;
        #1;
        check_val("async.dout", 32'(d0_dout), 32'd0);
        check_val("async.vld", 32'(d0_vld), 32'd0);
        check_val("async.cnt", 32'(d0_cnt), 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;

        // randomized traffic with occasional halt words and reset pulses
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(99) >= 4) d[7] = 1'b0;
            RST = ($urandom_range(99) < 3);
            cycle(1'($urandom_range(99) < 70), 1'($urandom_range(99) < 10), d,
                  1'($urandom_range(99) < 70));
        end
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
